// File: rtl/combat_referee_if.sv
// Port bundle between the match referee and its environment: player states and
// boxes in, match status, health and gating out.
interface combat_referee_if #(
    parameter int unsigned W = 10
);
    logic         start;
    logic [3:0]   p1_state;
    logic [3:0]   p2_state;
    logic [W-1:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
    logic [W-1:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [W-1:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
    logic [W-1:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
    logic [2:0]   game_state;
    logic [7:0]   p1_health;
    logic [7:0]   p2_health;
    logic         p1_freeze;
    logic         p2_freeze;
    logic         round_rst;
    logic [1:0]   hit_evt;
    logic [1:0]   p1_wins;
    logic [1:0]   p2_wins;
    logic [1:0]   winner;

    modport master (
        output start, p1_state, p2_state,
        output p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
        output p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
        output p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
        output p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
        input  game_state, p1_health, p2_health, p1_freeze, p2_freeze,
        input  round_rst, hit_evt, p1_wins, p2_wins, winner
    );

    modport slave (
        input  start, p1_state, p2_state,
        input  p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
        input  p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
        input  p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
        input  p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
        output game_state, p1_health, p2_health, p1_freeze, p2_freeze,
        output round_rst, hit_evt, p1_wins, p2_wins, winner
    );
endinterface

// File: rtl/combat_referee.sv
// Two-player match referee: hitbox/hurtbox hit detection, damage and hitstun,
// and round sequencing (countdown, fight, KO, match over).
module combat_referee #(
    parameter int unsigned W             = 10,
    parameter int unsigned MAX_HEALTH    = 100,
    parameter int unsigned DAMAGE        = 10,
    parameter int unsigned HITSTUN       = 8,
    parameter int unsigned COUNTDOWN     = 60,
    parameter int unsigned KO_HOLD       = 120,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter logic [3:0]  ATK_STATE     = 4'd4
) (
    input logic              clk,
    input logic              rst_n,
    combat_referee_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StCountdown = 3'd1,
        StFight     = 3'd2,
        StKo        = 3'd3,
        StMatchOver = 3'd4
    } state_e;

    localparam logic [7:0]  MaxHealth     = 8'(MAX_HEALTH);
    localparam logic [7:0]  Damage        = 8'(DAMAGE);
    localparam logic [7:0]  Hitstun       = 8'(HITSTUN);
    localparam logic [15:0] CountdownLast = 16'(COUNTDOWN - 1);
    localparam logic [15:0] KoHoldLast    = 16'(KO_HOLD - 1);
    localparam logic [1:0]  RoundsToWin   = 2'(ROUNDS_TO_WIN);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  p1_health_q, p1_health_d, p2_health_q, p2_health_d;
    logic [7:0]  p1_stun_q, p1_stun_d, p2_stun_q, p2_stun_d;
    logic        p1_used_q, p1_used_d, p2_used_q, p2_used_d;
    logic        round_rst_q, round_rst_d;
    logic [1:0]  hit_evt_q, hit_evt_d;
    logic [1:0]  p1_wins_q, p1_wins_d, p2_wins_q, p2_wins_d;
    logic [1:0]  winner_q, winner_d;
    logic        fight_live, p1_hits, p2_hits, new_round;

    // Closed-interval overlap on both axes with corners given in any order.
    function automatic logic overlap(input logic [W-1:0] ax1, ax2, ay1, ay2,
                                     input logic [W-1:0] bx1, bx2, by1, by2);
        logic [W-1:0] alx, ahx, aly, ahy, blx, bhx, bly, bhy;
        alx = (ax1 < ax2) ? ax1 : ax2;
        ahx = (ax1 < ax2) ? ax2 : ax1;
        aly = (ay1 < ay2) ? ay1 : ay2;
        ahy = (ay1 < ay2) ? ay2 : ay1;
        blx = (bx1 < bx2) ? bx1 : bx2;
        bhx = (bx1 < bx2) ? bx2 : bx1;
        bly = (by1 < by2) ? by1 : by2;
        bhy = (by1 < by2) ? by2 : by1;
        return (alx <= bhx) && (blx <= ahx) && (aly <= bhy) && (bly <= ahy);
    endfunction

    // A zero health still visible in FIGHT means KO is pending: no new hits.
    assign fight_live = (state_q == StFight) && (p1_health_q != 8'd0) && (p2_health_q != 8'd0);

    assign p1_hits = fight_live && (bus.p1_state == ATK_STATE) && !p1_used_q &&
                     overlap(bus.p1_hit_x1, bus.p1_hit_x2, bus.p1_hit_y1, bus.p1_hit_y2,
                             bus.p2_hurt_x1, bus.p2_hurt_x2, bus.p2_hurt_y1, bus.p2_hurt_y2);
    assign p2_hits = fight_live && (bus.p2_state == ATK_STATE) && !p2_used_q &&
                     overlap(bus.p2_hit_x1, bus.p2_hit_x2, bus.p2_hit_y1, bus.p2_hit_y2,
                             bus.p1_hurt_x1, bus.p1_hurt_x2, bus.p1_hurt_y1, bus.p1_hurt_y2);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p1_health_d = p1_health_q;
        p2_health_d = p2_health_q;
        p1_stun_d   = (p1_stun_q != 8'd0) ? p1_stun_q - 8'd1 : 8'd0;
        p2_stun_d   = (p2_stun_q != 8'd0) ? p2_stun_q - 8'd1 : 8'd0;
        p1_used_d   = (bus.p1_state == ATK_STATE) ? (p1_used_q | p1_hits) : 1'b0;
        p2_used_d   = (bus.p2_state == ATK_STATE) ? (p2_used_q | p2_hits) : 1'b0;
        round_rst_d = 1'b0;
        hit_evt_d   = 2'b00;
        p1_wins_d   = p1_wins_q;
        p2_wins_d   = p2_wins_q;
        winner_d    = winner_q;
        new_round   = 1'b0;

        case (state_q)
            StIdle: new_round = bus.start;
            StCountdown: begin
                if (cnt_q == CountdownLast) begin
                    state_d = StFight;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StFight: begin
                if ((p1_health_q == 8'd0) || (p2_health_q == 8'd0)) begin
                    state_d = StKo;
                    cnt_d   = 16'd0;
                    if (p1_health_q == 8'd0 && p2_health_q != 8'd0) p2_wins_d = p2_wins_q + 2'd1;
                    if (p2_health_q == 8'd0 && p1_health_q != 8'd0) p1_wins_d = p1_wins_q + 2'd1;
                end else begin
                    if (p1_hits) begin
                        p2_health_d  = (p2_health_q >= Damage) ? p2_health_q - Damage : 8'd0;
                        p2_stun_d    = Hitstun;
                        hit_evt_d[0] = 1'b1;
                    end
                    if (p2_hits) begin
                        p1_health_d  = (p1_health_q >= Damage) ? p1_health_q - Damage : 8'd0;
                        p1_stun_d    = Hitstun;
                        hit_evt_d[1] = 1'b1;
                    end
                end
            end
            StKo: begin
                if (cnt_q == KoHoldLast) begin
                    if ((p1_wins_q == RoundsToWin) || (p2_wins_q == RoundsToWin)) begin
                        state_d  = StMatchOver;
                        winner_d = (p1_wins_q == RoundsToWin) ? 2'd1 : 2'd2;
                    end else begin
                        new_round = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StMatchOver: begin
                if (bus.start) begin
                    p1_wins_d = 2'd0;
                    p2_wins_d = 2'd0;
                    winner_d  = 2'd0;
                    new_round = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (new_round) begin
            state_d     = StCountdown;
            cnt_d       = 16'd0;
            round_rst_d = 1'b1;
            p1_health_d = MaxHealth;
            p2_health_d = MaxHealth;
            p1_stun_d   = 8'd0;
            p2_stun_d   = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            p1_health_q <= MaxHealth;
            p2_health_q <= MaxHealth;
            p1_stun_q   <= 8'd0;
            p2_stun_q   <= 8'd0;
            p1_used_q   <= 1'b0;
            p2_used_q   <= 1'b0;
            round_rst_q <= 1'b0;
            hit_evt_q   <= 2'b00;
            p1_wins_q   <= 2'd0;
            p2_wins_q   <= 2'd0;
            winner_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p1_health_q <= p1_health_d;
            p2_health_q <= p2_health_d;
            p1_stun_q   <= p1_stun_d;
            p2_stun_q   <= p2_stun_d;
            p1_used_q   <= p1_used_d;
            p2_used_q   <= p2_used_d;
            round_rst_q <= round_rst_d;
            hit_evt_q   <= hit_evt_d;
            p1_wins_q   <= p1_wins_d;
            p2_wins_q   <= p2_wins_d;
            winner_q    <= winner_d;
        end
    end

    assign bus.game_state = state_q;
    assign bus.p1_health  = p1_health_q;
    assign bus.p2_health  = p2_health_q;
    assign bus.p1_freeze  = (state_q != StFight) || (p1_stun_q != 8'd0);
    assign bus.p2_freeze  = (state_q != StFight) || (p2_stun_q != 8'd0);
    assign bus.round_rst  = round_rst_q;
    assign bus.hit_evt    = hit_evt_q;
    assign bus.p1_wins    = p1_wins_q;
    assign bus.p2_wins    = p2_wins_q;
    assign bus.winner     = winner_q;

endmodule
